// File: rtl/lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_pkg
// Description : Shared types and sizing constants for the programmable LUT
//               neuron (table writer + distributed RAM).
// Revision    : 1.0 - initial release
// ============================================================================
package lut_pkg;

  // Default geometry: 8-bit packed fan-in code, 2-bit quantized output.
  localparam int LUT_IN_BITS  = 8;
  localparam int LUT_OUT_BITS = 2;

  // Table depth and width of the entry counter (must be able to hold DEPTH).
  localparam int DEPTH = 1 << LUT_IN_BITS;
  localparam int CNT_W = LUT_IN_BITS + 1;

  // Table-writer control states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } lut_state_e;

endpackage : lut_pkg
`default_nettype wire

// File: rtl/lut_ram_dist.sv
`default_nettype none
// ============================================================================
// Module      : lut_ram_dist
// Description : Simple dual-port distributed RAM holding the truth table.
//               Synchronous write port, registered read port. Contents are
//               not reset; only the read register is.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_ram_dist #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Table storage: one entry written per accepted config beat.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; holds its last value when no lookup is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : lut_ram_dist
`default_nettype wire

// File: rtl/lut_table_writer.sv
`default_nettype none
// ============================================================================
// Module      : lut_table_writer
// Description : Run-time programmable LUT neuron. Loads a 2^IN_BITS-entry
//               truth table serially from a valid/ready config stream, then
//               serves one registered lookup per cycle from that table.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_table_writer
  import lut_pkg::*;
#(
  parameter int IN_BITS  = LUT_IN_BITS,
  parameter int OUT_BITS = LUT_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_start,
  input  logic                i_cfg_valid,
  input  logic [OUT_BITS-1:0] i_cfg_data,
  output logic                o_cfg_ready,
  output logic                o_cfg_done,
  output logic [IN_BITS:0]    o_cfg_count,
  input  logic                i_lk_valid,
  input  logic [IN_BITS-1:0]  i_lk_addr,
  output logic                o_rsp_valid,
  output logic [OUT_BITS-1:0] o_rsp_data
);

  localparam int               C_CNT_W = IN_BITS + 1;
  localparam logic [IN_BITS-1:0] C_LAST = {IN_BITS{1'b1}};

  lut_state_e           r_state;
  logic [IN_BITS-1:0]   r_ptr;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_cfg_ready;
  logic                 r_cfg_done;
  logic                 r_rsp_valid;

  logic                 w_wr_en;
  logic                 w_rd_en;

  // A start pulse always wins over a concurrent config beat, so that beat
  // is dropped rather than written to the old pointer.
  assign w_wr_en = (r_state == S_LOAD) && i_cfg_valid && !i_cfg_start;
  // Lookups are gated by the current state, so a lookup coinciding with a
  // reload start is still answered from the old table.
  assign w_rd_en = (r_state == S_READY) && i_lk_valid;

  // Loader FSM: pointer, entry count and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_cfg_ready <= 1'b0;
      r_cfg_done  <= 1'b0;
    end else if (i_cfg_start) begin
      r_state     <= S_LOAD;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_cfg_ready <= 1'b1;
      r_cfg_done  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_wr_en) begin
            // Pointer wraps to 0 on the last entry and then stays put.
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt + C_CNT_W'(1);
            if (r_ptr == C_LAST) begin
              r_state     <= S_READY;
              r_cfg_ready <= 1'b0;
              r_cfg_done  <= 1'b1;
            end
          end
        end
        S_READY: begin
          r_cfg_ready <= 1'b0;
          r_cfg_done  <= 1'b1;
        end
        default: begin
          r_cfg_ready <= 1'b0;
          r_cfg_done  <= 1'b0;
        end
      endcase
    end
  end

  // Response valid flag tracks accepted lookups with one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= w_rd_en;
    end
  end

  lut_ram_dist #(
    .ADDR_W (IN_BITS),
    .DATA_W (OUT_BITS)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_en),
    .i_waddr (r_ptr),
    .i_wdata (i_cfg_data),
    .i_re    (w_rd_en),
    .i_raddr (i_lk_addr),
    .o_rdata (o_rsp_data)
  );

  assign o_cfg_ready = r_cfg_ready;
  assign o_cfg_done  = r_cfg_done;
  assign o_cfg_count = r_cnt;
  assign o_rsp_valid = r_rsp_valid;

endmodule : lut_table_writer
`default_nettype wire
